// File: rtl/bus_arbiter_rr_if.sv
// Shared-slave bus between N masters, the round-robin arbiter
// and one slave; packed per-master address/data lanes.
interface bus_arbiter_rr_if #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32
);
  logic [N_MASTERS-1:0]        m_req;
  logic [N_MASTERS-1:0]        m_valid;
  logic [N_MASTERS-1:0]        m_we;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [N_MASTERS-1:0]        m_gnt;
  logic [N_MASTERS-1:0]        m_ready;
  logic [N_MASTERS-1:0]        m_err;
  logic [DATA_W-1:0]           m_rdata;
  logic                        s_valid;
  logic                        s_we;
  logic [ADDR_W-1:0]           s_addr;
  logic [DATA_W-1:0]           s_wdata;
  logic                        s_ready;
  logic [DATA_W-1:0]           s_rdata;

  modport arb (
    input  m_req, m_valid, m_we, m_addr, m_wdata,
    input  s_ready, s_rdata,
    output m_gnt, m_ready, m_err, m_rdata,
    output s_valid, s_we, s_addr, s_wdata
  );

  modport master (
    output m_req, m_valid, m_we, m_addr, m_wdata,
    input  m_gnt, m_ready, m_err, m_rdata
  );

  modport slave (
    input  s_valid, s_we, s_addr, s_wdata,
    output s_ready, s_rdata
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: burst ownership, owner-to-slave mux,
// stall timeout abort.
module bus_arbiter_rr #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_rr_if.arb bus
);
  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [N_MASTERS-1:0] ONE = 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t               r_state;
  logic [IW-1:0]        r_owner;
  logic [IW-1:0]        r_ptr;
  logic [N_MASTERS-1:0] r_gnt;
  logic [CW-1:0]        r_cnt;

  logic [IW-1:0] w_sel;
  logic [IW-1:0] w_nxt;
  logic          w_any;
  logic          w_own;
  logic          w_valid;
  logic          w_stall;
  logic          w_done;
  logic          w_tmo;
  logic          w_rel;

  function automatic logic [IW-1:0] rr_idx(
    input logic [IW-1:0] p,
    input int            i
  );
    int s;
    s = int'(p) + i;
    if (s >= N_MASTERS) s = s - N_MASTERS;
    return IW'(s);
  endfunction

  // Scan from the highest offset down so the lowest offset wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (bus.m_req[rr_idx(r_ptr, i)]) begin
        w_any = 1'b1;
        w_sel = rr_idx(r_ptr, i);
      end
    end
  end

  assign w_nxt = (r_owner == IW'(N_MASTERS - 1)) ?
                 '0 : r_owner + 1'b1;

  assign w_own   = (r_state == OWNED);
  assign w_valid = w_own & bus.m_valid[r_owner] & r_gnt[r_owner];
  assign w_stall = w_valid & ~bus.s_ready;
  assign w_done  = w_valid & bus.s_ready;
  assign w_tmo   = w_stall & (r_cnt == CW'(TIMEOUT - 1));
  assign w_rel   = ~bus.m_req[r_owner] & ~w_stall;

  assign bus.m_gnt   = r_gnt;
  assign bus.m_ready = r_gnt & {N_MASTERS{w_done}};
  assign bus.m_err   = r_gnt & {N_MASTERS{w_tmo}};
  assign bus.m_rdata = w_own ? bus.s_rdata : '0;
  assign bus.s_valid = w_valid;
  assign bus.s_we    = w_own & bus.m_we[r_owner];
  assign bus.s_addr  = w_own ?
                       bus.m_addr[r_owner*ADDR_W +: ADDR_W] : '0;
  assign bus.s_wdata = w_own ?
                       bus.m_wdata[r_owner*DATA_W +: DATA_W] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_any) begin
            r_state <= OWNED;
            r_owner <= w_sel;
            r_gnt   <= ONE << w_sel;
          end
        end
        OWNED: begin
          if (w_tmo || w_rel) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= w_nxt;
            r_cnt   <= '0;
          end else if (w_stall) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
